// File: rtl/ram_dma.sv
// Byte-wide RAM DMA engine: ascending copy or fill over a single-port RAM.
// Copy runs RD/WR pairs; fill issues back-to-back writes.
module ram_dma #(
  parameter  int KB = 16,
  localparam int AW = $clog2(KB*1024)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW:0]   len,
  input  logic [7:0]    fill,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          ce,
  output logic          we,
  output logic [7:0]    d,
  input  logic [7:0]    q,
  output logic [AW-1:0] a
);

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} st_t;

  localparam logic [AW:0]   MAXLEN = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   CNT1   = (AW+1)'(1);
  localparam logic [AW-1:0] ONE    = AW'(1);

  st_t           st;
  logic          mode_r;
  logic [7:0]    fill_r;
  logic [AW-1:0] sa;
  logic [AW-1:0] da;
  logic [AW:0]   cnt;
  logic [AW:0]   len_sat;

  assign len_sat = len[AW] ? MAXLEN : len;

  // read data is only valid during the WR that follows its RD
  assign d = (st == WR) ? (mode_r ? fill_r : q) : 8'h00;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st     <= IDLE;
      ce     <= 1'b0;
      we     <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
      a      <= '0;
      sa     <= '0;
      da     <= '0;
      cnt    <= '0;
      mode_r <= 1'b0;
      fill_r <= '0;
    end else begin
      unique case (st)
        IDLE: begin
          if (start) begin
            mode_r <= mode;
            fill_r <= fill;
            sa     <= src;
            da     <= dst;
            cnt    <= len_sat;
            busy   <= 1'b1;
            if (len == '0) begin
              st   <= FIN;
              done <= 1'b1;
            end else if (mode) begin
              st <= WR;
              ce <= 1'b1;
              we <= 1'b0;
              a  <= dst;
            end else begin
              st <= RD;
              ce <= 1'b1;
              we <= 1'b1;
              a  <= src;
            end
          end
        end
        RD: begin
          if (abort) begin
            st   <= IDLE;
            ce   <= 1'b0;
            we   <= 1'b1;
            busy <= 1'b0;
          end else begin
            st <= WR;
            we <= 1'b0;
            a  <= da;
          end
        end
        WR: begin
          if (abort) begin
            st   <= IDLE;
            ce   <= 1'b0;
            we   <= 1'b1;
            busy <= 1'b0;
          end else begin
            cnt <= cnt - CNT1;
            sa  <= sa + ONE;
            da  <= da + ONE;
            if (cnt == CNT1) begin
              st   <= FIN;
              ce   <= 1'b0;
              we   <= 1'b1;
              done <= 1'b1;
            end else if (mode_r) begin
              a <= da + ONE;
            end else begin
              st <= RD;
              we <= 1'b1;
              a  <= sa + ONE;
            end
          end
        end
        FIN: begin
          st   <= IDLE;
          busy <= 1'b0;
          done <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_dma.sv
// Bench for ram_dma with KB=1: attached RAM, vector table,
// async reset sequence and randomized transfers against a byte model.
module tb_ram_dma;
  localparam int KB = 1;
  localparam int AW = 10;
  localparam int N  = 1024;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          mode;
  logic          abort;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [AW-1:0] a;
  logic [AW:0]   len;
  logic [7:0]    fill;
  logic [7:0]    d;
  logic [7:0]    q;
  logic          busy;
  logic          done;
  logic          ce;
  logic          we;

  logic          pl_we = 1'b0;
  logic [AW-1:0] pl_a = '0;
  logic [7:0]    pl_d = '0;

  logic [7:0] mem  [N];
  logic [7:0] refm [N];

  int checks = 0;
  int errors = 0;

  ram_dma #(.KB(KB)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode),
    .src(src), .dst(dst), .len(len), .fill(fill), .abort(abort),
    .busy(busy), .done(done), .ce(ce), .we(we), .d(d), .q(q), .a(a)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (pl_we) mem[pl_a] <= pl_d;
    else if (ce) begin
      if (!we) mem[a] <= d;
      else q <= mem[a];
    end
  end

  typedef struct {
    bit m;
    int s, dt, l, f, ab, rs;
    int eb, ew, er, ed;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic poke(input int ad, input int val);
    @(negedge clock);
    pl_we = 1'b1;
    pl_a = AW'(ad);
    pl_d = 8'(val);
    refm[ad] = 8'(val);
    @(posedge clock);
    #1 pl_we = 1'b0;
  endtask

  task automatic model(input bit m, input int s, input int dt,
                       input int n, input int f);
    for (int i = 0; i < n; i++)
      refm[(dt + i) % N] = m ? 8'(f) : refm[(s + i) % N];
  endtask

  task automatic check_mem(input string nm);
    int bad;
    bad = -1;
    for (int i = 0; i < N; i++)
      if (bad < 0 && mem[i] !== refm[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s mem[%0h] got %0h want %0h",
               nm, bad, mem[bad], refm[bad]);
    end
  endtask

  task automatic run(input bit m, input int s, input int dt, input int l,
                     input int f, input int ab, input int rs,
                     output int b, output int w, output int r,
                     output int dn);
    b = 0; w = 0; r = 0; dn = 0;
    @(negedge clock);
    start = 1'b1;
    mode = m;
    src = AW'(s);
    dst = AW'(dt);
    len = (AW+1)'(l);
    fill = 8'(f);
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!busy) break;
      b++;
      if (done) dn++;
      if (ce && !we) w++;
      if (ce && we) r++;
      abort = (ab > 0 && w == ab && ce && we);
      if (rs != 0 && i == 1) begin
        start = 1'b1;
        mode = ~m;
        src = '0;
        dst = '0;
        len = (AW+1)'(5);
        fill = 8'h3C;
      end else start = 1'b0;
      @(negedge clock);
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    int b, w, r, dn, n, m, s, dt, l, f;
    reset = 1'b1;
    start = 1'b0;
    mode = 1'b0;
    abort = 1'b0;
    src = '0;
    dst = '0;
    len = '0;
    fill = '0;
    #2;
    chk("rst ce", ce, 0);
    chk("rst we", we, 1);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst a", a, 0);
    chk("rst d", d, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < N; i++) poke(i, $urandom_range(0, 255));
    poke('h100, 'h11);
    poke('h101, 'h22);
    poke('h102, 'h33);
    poke('h103, 'h44);
    poke('h010, 5);

    tbl[0] = '{0, 'h100, 'h200, 4,     0,     0, 0, 9,    4,    4,    1};
    tbl[1] = '{1, 0,     'h3FE, 4,     'hA5,  0, 0, 5,    4,    0,    1};
    tbl[2] = '{0, 'h123, 'h321, 0,     0,     0, 0, 1,    0,    0,    1};
    tbl[3] = '{0, 'h300, 'h380, 8,     0,     3, 0, 7,    3,    4,    0};
    tbl[4] = '{0, 'h010, 'h011, 3,     0,     0, 0, 7,    3,    3,    1};
    tbl[5] = '{0, 'h140, 'h240, 6,     0,     0, 1, 13,   6,    6,    1};
    tbl[6] = '{0, 0,     'h200, 'h7FF, 0,     0, 0, 2049, 1024, 1024, 1};

    foreach (tbl[k]) begin
      run(tbl[k].m, tbl[k].s, tbl[k].dt, tbl[k].l, tbl[k].f,
          tbl[k].ab, tbl[k].rs, b, w, r, dn);
      n = tbl[k].ab > 0 ? tbl[k].ab : (tbl[k].l > N ? N : tbl[k].l);
      model(tbl[k].m, tbl[k].s, tbl[k].dt, n, tbl[k].f);
      chk($sformatf("v%0d busy", k), b, tbl[k].eb);
      chk($sformatf("v%0d writes", k), w, tbl[k].ew);
      chk($sformatf("v%0d reads", k), r, tbl[k].er);
      chk($sformatf("v%0d done", k), dn, tbl[k].ed);
      chk($sformatf("v%0d end_busy", k), busy, 0);
      chk($sformatf("v%0d end_ce", k), ce, 0);
      check_mem($sformatf("v%0d", k));
      if (k == 0)
        for (int j = 0; j < 4; j++)
          chk($sformatf("copy byte%0d", j), mem['h200 + j], 'h11 * (j + 1));
      if (k == 1) begin
        chk("fill 3FE", mem['h3FE], 'hA5);
        chk("fill 3FF", mem['h3FF], 'hA5);
        chk("fill 000", mem[0], 'hA5);
        chk("fill 001", mem[1], 'hA5);
      end
      if (k == 4)
        for (int j = 1; j < 4; j++)
          chk($sformatf("overlap %0d", j), mem['h010 + j], 5);
    end

    @(negedge clock);
    start = 1'b1;
    mode = 1'b1;
    dst = AW'('h050);
    len = (AW+1)'(100);
    fill = 8'h5A;
    @(negedge clock);
    start = 1'b0;
    w = 0;
    for (int i = 0; i < 10; i++) begin
      if (ce && !we) w++;
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    #1;
    chk("async ce", ce, 0);
    chk("async busy", busy, 0);
    chk("async done", done, 0);
    chk("async writes", w, 10);
    model(1, 0, 'h050, w, 'h5A);
    @(negedge clock);
    reset = 1'b0;
    check_mem("after reset");

    for (int t = 0; t < 12; t++) begin
      m = $urandom_range(0, 1);
      s = $urandom_range(0, N - 1);
      dt = $urandom_range(0, N - 1);
      l = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2047)
                                      : $urandom_range(0, 24);
      f = $urandom_range(0, 255);
      run(m[0], s, dt, l, f, 0, 0, b, w, r, dn);
      n = l > N ? N : l;
      model(m[0], s, dt, n, f);
      chk($sformatf("r%0d busy", t), b,
          n == 0 ? 1 : (m != 0 ? n : 2 * n) + 1);
      chk($sformatf("r%0d writes", t), w, n);
      chk($sformatf("r%0d reads", t), r, m != 0 ? 0 : n);
      chk($sformatf("r%0d done", t), dn, 1);
      check_mem($sformatf("r%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
